wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that sits directly upstream of `reg_writer`. It collects results from three producers (single-cycle ALU, multi-cycle FPU, load/store unit) and issues at most one register write per cycle on the `r_gfflag`/`r_num`/`r_data`/`enable` bus that `reg_writer` consumes. FPU and LSU results are buffered in per-lane FIFOs. FIFO lanes are served round-robin. A starvation counter guarantees that buffered results drain even under continuous ALU traffic.

## Interface
Parameters:
- `DEPTH`, 4: entries per buffered lane (FPU, LSU); power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may lose to the ALU before the ALU is stalled.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle (combinational).
- `alu_gfflag` / `alu_num` / `alu_data`  in  1/5/32  target file (0 = general, 1 = float), register index, value.
- `fpu_valid`, `fpu_ready`, `fpu_gfflag`, `fpu_num`, `fpu_data`: same set for the FPU lane.
- `lsu_valid`, `lsu_ready`, `lsu_gfflag`, `lsu_num`, `lsu_data`: same set for the LSU lane.
- `r_gfflag`  out  1  registered write target file, to `reg_writer`.
- `r_num`  out  5  registered write index.
- `r_data`  out  32  registered write data.
- `enable`  out  1  registered write strobe; exactly one write per cycle when high.
- `busy`  out  1  high while any FIFO is non-empty (combinational from state).

## Operation
- **Handshake.** A transfer occurs when `valid && ready` on a rising edge. Producers hold their payload until the transfer.
- **FIFO ready.** `fpu_ready` = FPU FIFO count < `DEPTH`; `lsu_ready` likewise. Both depend on registered count only. A full FIFO does not accept in the same cycle it pops.
- **General register 0.** An accepted entry with `gfflag=0, num=0` is discarded: it is not enqueued or issued, and the handshake still completes.
- **Grant per cycle, in priority order:**
  1. If `wait_cnt >= STARVE_LIMIT` and a FIFO is non-empty: grant a FIFO head, with `alu_ready=0`.
  2. Else if `alu_valid`: grant the ALU, with `alu_ready=1`.
  3. Else if a FIFO is non-empty: grant a FIFO head.
  4. Else no grant.
- **ALU ready.** `alu_ready=1` whenever the starvation condition is false, including when the ALU is idle.
- **FIFO choice.** If only one FIFO is non-empty, it is chosen. If both are non-empty, choose by the `rr` bit (0 = FPU, 1 = LSU); `rr` toggles after every FIFO grant made with both non-empty.
- **Granted entry.** It is written into the output registers with `enable=1` at that edge, and the granted FIFO pops. With no grant, `enable=0`; `r_*` hold their previous values.
- **Starvation counter.** `wait_cnt` is 3 bits, saturating. It increments on a cycle where some FIFO is non-empty and the ALU is granted. It clears on any FIFO grant, or when both FIFOs are empty.
- **Ordering.** No ordering is enforced between lanes. Order within a lane is preserved.
- **Reset (async, `rstn=0`).**
  - `enable=0`, `r_gfflag=0`, `r_num=0`, `r_data=0`.
  - Both FIFOs empty, `rr=0`, `wait_cnt=0`.
  - Resulting outputs: `busy=0`, `fpu_ready=lsu_ready=1`, `alu_ready=1`.
  - Reset mid-operation drops all buffered entries.

## Timing
- **ALU latency.** Accepted at edge N → `enable=1` with the data during cycle N..N+1.
- **FIFO latency.** Enqueued at edge N → earliest issue at edge N+1 → visible after N+1 (two cycles minimum).
- **Throughput.** One write per cycle total. Each FIFO accepts one entry per cycle.
- **Wrap-around.** FIFO pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.
- **Simultaneous push and pop on the same FIFO** (not full): count is unchanged and data order is preserved.

## Test plan
- **After reset:** `rstn` low mid-stream with 3 FPU entries queued → `enable=0`, `r_num=0`, `busy=0`, `fpu_ready=1` immediately (asynchronous).
- **ALU alone:** `alu_valid` with (0, 5, 0xDEADBEEF) at edge N → `enable=1`, `r_gfflag=0`, `r_num=5`, `r_data=0xDEADBEEF` after edge N, `enable=0` after N+1.
- **Register 0 drop:** FPU pushes (0, 0, 0x1234) and then (1, 0, 0x5678) → only one write occurs, with `r_gfflag=1`, `r_num=0`, `r_data=0x5678`.
- **Full FIFO:** with `DEPTH=4` and the ALU valid every cycle, push 4 LSU entries → `lsu_ready=0` after the 4th push. After `STARVE_LIMIT` ALU grants, `alu_ready=0` for one cycle and the LSU head issues.
- **Round-robin:** both FIFOs hold 2 entries, ALU idle → issue order FPU0, LSU0, FPU1, LSU1 on consecutive cycles, then `busy=0`.
- **Wrap-around:** 10 FPU entries streamed with `DEPTH=4` and interleaved pops → all 10 values issue in push order, with none lost or duplicated.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: three producer handshakes in, one registered
// register-file write port and a busy flag out.
interface wb_arbiter_if;
    logic        alu_valid, alu_ready, alu_gfflag;
    logic [4:0]  alu_num;
    logic [31:0] alu_data;
    logic        fpu_valid, fpu_ready, fpu_gfflag;
    logic [4:0]  fpu_num;
    logic [31:0] fpu_data;
    logic        lsu_valid, lsu_ready, lsu_gfflag;
    logic [4:0]  lsu_num;
    logic [31:0] lsu_data;
    logic        r_gfflag;
    logic [4:0]  r_num;
    logic [31:0] r_data;
    logic        enable;
    logic        busy;

    modport slave (
        input  alu_valid, alu_gfflag, alu_num, alu_data,
        input  fpu_valid, fpu_gfflag, fpu_num, fpu_data,
        input  lsu_valid, lsu_gfflag, lsu_num, lsu_data,
        output alu_ready, fpu_ready, lsu_ready,
        output r_gfflag, r_num, r_data, enable, busy
    );

    modport master (
        output alu_valid, alu_gfflag, alu_num, alu_data,
        output fpu_valid, fpu_gfflag, fpu_num, fpu_data,
        output lsu_valid, lsu_gfflag, lsu_num, lsu_data,
        input  alu_ready, fpu_ready, lsu_ready,
        input  r_gfflag, r_num, r_data, enable, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU direct path plus buffered FPU/LSU lanes, round-robin
// between lanes, with a starvation counter that stalls the ALU to drain them.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    wb_arbiter_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          NUM_LANES = 2;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [2:0]  LIM       = 3'(STARVE_LIMIT);

    typedef struct packed {
        logic        gf;
        logic [4:0]  num;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t [NUM_LANES-1:0] w_in_ent, w_head;
    logic    [NUM_LANES-1:0] w_in_valid, w_ready, w_ne, w_push, w_pop;
    wb_ent_t                 w_alu_ent;
    logic                    w_any, w_both, w_starve, w_alu_gnt, w_fifo_gnt;
    logic                    w_sel, w_alu_keep;

    logic       r_rr;
    logic [2:0] r_wait;
    logic       r_enable;
    wb_ent_t    r_out;

    // Writes to general register 0 are swallowed at the handshake.
    function automatic logic is_keep(wb_ent_t e);
        return e.gf || (e.num != 5'd0);
    endfunction

    assign w_in_valid  = {bus.lsu_valid, bus.fpu_valid};
    assign w_in_ent[0] = {bus.fpu_gfflag, bus.fpu_num, bus.fpu_data};
    assign w_in_ent[1] = {bus.lsu_gfflag, bus.lsu_num, bus.lsu_data};
    assign w_alu_ent   = {bus.alu_gfflag, bus.alu_num, bus.alu_data};
    assign w_alu_keep  = is_keep(w_alu_ent);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        wb_ent_t       r_mem [DEPTH];
        logic [AW-1:0] r_wp, r_rp;
        logic [AW:0]   r_cnt;

        // Ready looks only at the registered count, so a full lane never
        // accepts in the cycle it pops.
        assign w_ready[l] = r_cnt < FULL_CNT;
        assign w_ne[l]    = r_cnt != '0;
        assign w_push[l]  = w_in_valid[l] && w_ready[l] && is_keep(w_in_ent[l]);
        assign w_head[l]  = r_mem[r_rp];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[l]) r_wp <= r_wp + 1'b1;
                if (w_pop[l])  r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + (AW+1)'(w_push[l]) - (AW+1)'(w_pop[l]);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[l]) r_mem[r_wp] <= w_in_ent[l];
        end
    end

    always_comb begin
        w_any      = |w_ne;
        w_both     = &w_ne;
        w_starve   = (r_wait >= LIM) && w_any;
        w_alu_gnt  = !w_starve && bus.alu_valid;
        w_fifo_gnt = w_any && !w_alu_gnt;
        w_sel      = w_both ? r_rr : w_ne[1];
        w_pop      = '0;
        if (w_fifo_gnt) w_pop[w_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr     <= 1'b0;
            r_wait   <= '0;
            r_enable <= 1'b0;
            r_out    <= '0;
        end else begin
            if (w_fifo_gnt && w_both) r_rr <= !r_rr;
            if (w_fifo_gnt || !w_any)
                r_wait <= '0;
            else if (w_alu_gnt && r_wait != 3'd7)
                r_wait <= r_wait + 3'd1;
            r_enable <= w_fifo_gnt || (w_alu_gnt && w_alu_keep);
            if (w_fifo_gnt)
                r_out <= w_head[w_sel];
            else if (w_alu_gnt && w_alu_keep)
                r_out <= w_alu_ent;
        end
    end

    assign bus.alu_ready = !w_starve;
    assign bus.fpu_ready = w_ready[0];
    assign bus.lsu_ready = w_ready[1];
    assign bus.busy      = w_any;
    assign bus.enable    = r_enable;
    assign bus.r_gfflag  = r_out.gf;
    assign bus.r_num     = r_out.num;
    assign bus.r_data    = r_out.data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the write-back rules.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIM   = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: entries are {gfflag, num, data}.
    logic [37:0] fq[$];
    logic [37:0] lq[$];
    bit          m_rr;
    int          m_wait;
    bit          e_alu_rdy, e_fpu_rdy, e_lsu_rdy, e_busy, e_en;
    logic [37:0] e_out;
    bit          m_alu_acc, m_fpu_acc, m_lsu_acc;
    logic        o_alu_rdy, o_fpu_rdy, o_lsu_rdy, o_busy;

    function automatic bit is_r0(logic [37:0] e);
        return (e[37] == 1'b0) && (e[36:32] == 5'd0);
    endfunction

    task automatic model_reset();
        fq.delete();
        lq.delete();
        m_rr   = 0;
        m_wait = 0;
        e_en   = 0;
        e_out  = '0;
    endtask

    task automatic model_step();
        logic [37:0] a, f, l;
        bit any, starve, alu_g, fifo_g, pick_lsu;
        a = {bus.alu_gfflag, bus.alu_num, bus.alu_data};
        f = {bus.fpu_gfflag, bus.fpu_num, bus.fpu_data};
        l = {bus.lsu_gfflag, bus.lsu_num, bus.lsu_data};
        any       = (fq.size() > 0) || (lq.size() > 0);
        starve    = (m_wait >= LIM) && any;
        e_alu_rdy = !starve;
        e_fpu_rdy = fq.size() < DEPTH;
        e_lsu_rdy = lq.size() < DEPTH;
        e_busy    = any;
        alu_g     = !starve && bus.alu_valid;
        fifo_g    = any && !alu_g;
        m_alu_acc = alu_g;
        m_fpu_acc = bus.fpu_valid && e_fpu_rdy;
        m_lsu_acc = bus.lsu_valid && e_lsu_rdy;
        e_en = 0;
        if (alu_g && !is_r0(a)) begin
            e_en  = 1;
            e_out = a;
        end
        if (fifo_g) begin
            if (fq.size() > 0 && lq.size() > 0) begin
                pick_lsu = m_rr;
                m_rr     = !m_rr;
            end else begin
                pick_lsu = lq.size() > 0;
            end
            e_en  = 1;
            e_out = pick_lsu ? lq.pop_front() : fq.pop_front();
        end
        if (fifo_g || !any) m_wait = 0;
        else if (alu_g && m_wait < 7) m_wait++;
        if (m_fpu_acc && !is_r0(f)) fq.push_back(f);
        if (m_lsu_acc && !is_r0(l)) lq.push_back(l);
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_gfflag = 0; bus.alu_num = '0; bus.alu_data = '0;
        bus.fpu_valid = 0; bus.fpu_gfflag = 0; bus.fpu_num = '0; bus.fpu_data = '0;
        bus.lsu_valid = 0; bus.lsu_gfflag = 0; bus.lsu_num = '0; bus.lsu_data = '0;
    endtask

    // Called at posedge+1; samples combinational outputs, advances the model
    // and returns at the next posedge+1.
    task automatic tick();
        #1;
        o_alu_rdy = bus.alu_ready;
        o_fpu_rdy = bus.fpu_ready;
        o_lsu_rdy = bus.lsu_ready;
        o_busy    = bus.busy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        model_reset();
        #12;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0d want 0", bus.enable); end
        checks++; if (bus.r_num !== 5'd0) begin errors++; $display("FAIL reset_num: got %0d want 0", bus.r_num); end
        checks++; if (bus.r_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.r_data); end
        checks++; if (bus.r_gfflag !== 1'b0) begin errors++; $display("FAIL reset_gf: got %0d want 0", bus.r_gfflag); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", bus.busy); end
        checks++; if ({bus.alu_ready, bus.fpu_ready, bus.lsu_ready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b want 111", {bus.alu_ready, bus.fpu_ready, bus.lsu_ready}); end
        // Queue three FPU entries behind a busy ALU, then reset mid-stream.
        bus.alu_valid = 1; bus.alu_gfflag = 0; bus.alu_num = 5'd3; bus.alu_data = 32'hA000_0003;
        for (int i = 0; i < 3; i++) begin
            bus.fpu_valid = 1; bus.fpu_gfflag = 1; bus.fpu_num = 5'(i + 1); bus.fpu_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        idle_inputs();
        checks++; if (bus.busy !== 1'b1 || fq.size() != 3) begin
            errors++; $display("FAIL midrst_pre_busy: got %0d want 1 (model depth %0d)", bus.busy, fq.size()); end
        #2;
        rstn = 0;
        #1;
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %0d want 0", bus.enable); end
        checks++; if (bus.r_num !== 5'd0) begin errors++; $display("FAIL midrst_num: got %0d want 0", bus.r_num); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0d want 0", bus.busy); end
        checks++; if (bus.fpu_ready !== 1'b1) begin errors++; $display("FAIL midrst_fpu_ready: got %0d want 1", bus.fpu_ready); end
        model_reset();
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.enable !== 1'b0) begin
            errors++; $display("FAIL midrst_dropped: got busy %0d en %0d want 0 0", bus.busy, bus.enable); end
    endtask

    task automatic test_alu_alone();
        do_reset();
        bus.alu_valid = 1; bus.alu_gfflag = 0; bus.alu_num = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        tick();
        bus.alu_valid = 0;
        checks++; if (o_alu_rdy !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0d want 1", o_alu_rdy); end
        checks++; if (bus.enable !== 1'b1) begin errors++; $display("FAIL alu_enable: got %0d want 1", bus.enable); end
        checks++; if ({bus.r_gfflag, bus.r_num, bus.r_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL alu_write: got %0d/%0d/%h want 0/5/deadbeef", bus.r_gfflag, bus.r_num, bus.r_data); end
        tick();
        checks++; if (bus.enable !== 1'b0) begin errors++; $display("FAIL alu_enable_off: got %0d want 0", bus.enable); end
        checks++; if (bus.r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_hold: got %h want deadbeef", bus.r_data); end
    endtask

    task automatic test_reg0_drop();
        int          nw;
        logic [37:0] w;
        do_reset();
        nw = 0;
        w  = '0;
        bus.fpu_valid = 1; bus.fpu_gfflag = 0; bus.fpu_num = 5'd0; bus.fpu_data = 32'h1234;
        tick();
        if (bus.enable) begin nw++; w = {bus.r_gfflag, bus.r_num, bus.r_data}; end
        bus.fpu_gfflag = 1; bus.fpu_data = 32'h5678;
        tick();
        if (bus.enable) begin nw++; w = {bus.r_gfflag, bus.r_num, bus.r_data}; end
        bus.fpu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.enable) begin nw++; w = {bus.r_gfflag, bus.r_num, bus.r_data}; end
        end
        checks++; if (nw != 1) begin errors++; $display("FAIL r0_count: got %0d want 1", nw); end
        checks++; if (w !== {1'b1, 5'd0, 32'h5678}) begin errors++; $display("FAIL r0_write: got %h want %h", w, {1'b1, 5'd0, 32'h5678}); end
    endtask

    task automatic test_full_fifo();
        int n;
        do_reset();
        bus.alu_valid = 1; bus.alu_gfflag = 0; bus.alu_num = 5'd7; bus.alu_data = 32'hA000_0007;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_valid = 1; bus.lsu_gfflag = 1; bus.lsu_num = 5'(i + 1); bus.lsu_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        bus.lsu_valid = 0;
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL full_lsu_ready: got %0d want 0", bus.lsu_ready); end
        tick();
        checks++; if (o_alu_rdy !== 1'b1 || bus.r_data !== 32'hA000_0007) begin
            errors++; $display("FAIL full_fourth_alu: got rdy %0d data %h want 1 a0000007", o_alu_rdy, bus.r_data); end
        tick();
        checks++; if (o_alu_rdy !== 1'b0) begin errors++; $display("FAIL full_starve_stall: got %0d want 0", o_alu_rdy); end
        checks++; if ({bus.enable, bus.r_gfflag, bus.r_num, bus.r_data} !== {1'b1, 1'b1, 5'd1, 32'hC000_0000}) begin
            errors++; $display("FAIL full_lsu_issue: got %0d/%0d/%0d/%h want 1/1/1/c0000000", bus.enable, bus.r_gfflag, bus.r_num, bus.r_data); end
        checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin
            errors++; $display("FAIL full_after: got alu %0d lsu %0d want 1 1", bus.alu_ready, bus.lsu_ready); end
        bus.alu_valid = 0;
        n = 0;
        while (bus.busy && n < 20) begin tick(); n++; end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_drain: got busy %0d want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [31:0] want [4];
        want[0] = 32'hF000_0000; want[1] = 32'hB000_0000;
        want[2] = 32'hF000_0001; want[3] = 32'hB000_0001;
        do_reset();
        bus.alu_valid = 1; bus.alu_gfflag = 0; bus.alu_num = 5'd9; bus.alu_data = 32'hA000_0009;
        bus.fpu_valid = 1; bus.fpu_gfflag = 0; bus.fpu_num = 5'd1; bus.fpu_data = want[0];
        bus.lsu_valid = 1; bus.lsu_gfflag = 0; bus.lsu_num = 5'd2; bus.lsu_data = want[1];
        tick();
        bus.fpu_num = 5'd3; bus.fpu_data = want[2];
        bus.lsu_num = 5'd4; bus.lsu_data = want[3];
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.enable !== 1'b1 || bus.r_data !== want[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got en %0d data %h want 1 %h", i, bus.enable, bus.r_data, want[i]); end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_busy: got %0d want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int idx, cyc;
        do_reset();
        idx = 0;
        cyc = 0;
        while ((idx < 10 || got.size() < 10) && cyc < 300) begin
            bus.fpu_valid = idx < 10; bus.fpu_gfflag = 1; bus.fpu_num = 5'(idx + 1);
            bus.fpu_data  = 32'hF000_0000 + 32'(idx);
            bus.alu_valid = $urandom_range(0, 99) < 70; bus.alu_gfflag = 1; bus.alu_num = 5'd2;
            bus.alu_data  = 32'hA000_0000 | 32'($urandom_range(0, 65535));
            tick();
            if (m_fpu_acc && idx < 10) idx++;
            if (bus.enable && bus.r_data[31:28] == 4'hF) got.push_back(bus.r_data);
            cyc++;
        end
        idle_inputs();
        checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            checks++; if (got[i] !== 32'hF000_0000 + 32'(i)) begin
                errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 32'hF000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            checks++; if ({o_alu_rdy, o_fpu_rdy, o_lsu_rdy, o_busy} !== {e_alu_rdy, e_fpu_rdy, e_lsu_rdy, e_busy}) begin
                errors++; $display("FAIL rand_comb[%0d]: got %b want %b", c, {o_alu_rdy, o_fpu_rdy, o_lsu_rdy, o_busy},
                                   {e_alu_rdy, e_fpu_rdy, e_lsu_rdy, e_busy}); end
            checks++; if (bus.enable !== e_en) begin errors++; $display("FAIL rand_enable[%0d]: got %0d want %0d", c, bus.enable, e_en); end
            checks++; if ({bus.r_gfflag, bus.r_num, bus.r_data} !== e_out) begin
                errors++; $display("FAIL rand_write[%0d]: got %h want %h", c, {bus.r_gfflag, bus.r_num, bus.r_data}, e_out); end
            if (!bus.alu_valid || m_alu_acc) begin
                bus.alu_valid = $urandom_range(0, 99) < 60; bus.alu_gfflag = 1'($urandom_range(0, 1));
                bus.alu_num = 5'($urandom_range(1, 31)); bus.alu_data = $urandom();
            end
            if (!bus.fpu_valid || m_fpu_acc) begin
                bus.fpu_valid = $urandom_range(0, 99) < 40; bus.fpu_gfflag = 1'($urandom_range(0, 1));
                bus.fpu_num = 5'($urandom_range(0, 31)); bus.fpu_data = $urandom();
            end
            if (!bus.lsu_valid || m_lsu_acc) begin
                bus.lsu_valid = $urandom_range(0, 99) < 40; bus.lsu_gfflag = 1'($urandom_range(0, 1));
                bus.lsu_num = 5'($urandom_range(0, 31)); bus.lsu_data = $urandom();
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_alone();
        test_reg0_drop();
        test_full_fifo();
        test_round_robin();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
